// File: rtl/tmc_onchip_ram_pipe.sv
// Avalon-MM single-port on-chip RAM slave with pipelined reads, power-up clear and range protection.
// Optional per-byte even parity storage and sticky error flag: define TMC_ONCHIP_RAM_PARITY_EN.
module tmc_onchip_ram_pipe #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 8192,
    parameter int ADDR_W         = 13,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                init_done,
    output logic                parity_err
);

    localparam int NB    = DATA_W / 8;
`ifdef TMC_ONCHIP_RAM_PARITY_EN
    localparam int PW    = NB;
`else
    localparam int PW    = 0;
`endif
    localparam int MEM_W = DATA_W + PW;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [MEM_W-1:0]   ram [DEPTH];

    logic               in_range;
    logic [IDX_W-1:0]   addr_idx;
    logic               acc, wr_acc, rd_acc;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_idx;
    logic [DATA_W-1:0]  ram_wdata;
    logic [NB-1:0]      ram_be;
    logic [MEM_W-1:0]   rd_word;
    logic [MEM_W-1:0]   s1_q, s1_d;
    logic [MEM_W-1:0]   out_word;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY:0]   vld_pipe;

    assign in_range    = {1'b0, address} < DEPTH_A;
    assign addr_idx    = address[IDX_W-1:0];
    assign waitrequest = (state_q != S_RUN) | ~clken;
    assign init_done   = (state_q == S_RUN);
    assign acc         = chipselect & (read | write) & ~waitrequest;
    assign wr_acc      = acc & write;
    // A simultaneous read+write is treated purely as a write.
    assign rd_acc      = acc & read & ~write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clken && state_q == S_INIT) begin
            if (CLEAR_ON_RESET == 0 || cnt_q == LAST_IDX) begin
                state_d = S_RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_idx   = addr_idx;
        ram_wdata = writedata;
        ram_be    = byteenable;
        if (state_q == S_INIT && CLEAR_ON_RESET != 0) begin
            ram_we    = clken;
            ram_idx   = cnt_q;
            ram_wdata = '0;
            ram_be    = '1;
        end else if (wr_acc && in_range) begin
            ram_we = 1'b1;
        end
    end

    // Storage array is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < NB; b++) begin
                if (ram_be[b]) begin
                    ram[ram_idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
`ifdef TMC_ONCHIP_RAM_PARITY_EN
                    ram[ram_idx][DATA_W+b] <= ^ram_wdata[b*8 +: 8];
`endif
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = ram[addr_idx];
    end

    always_comb begin
        s1_d = s1_q;
        if (clken && rd_acc) s1_d = rd_word;
    end

    // Valid bits only advance on enabled cycles, so frozen reads are neither lost nor repeated.
    assign vld_pipe = {vld_q, rd_acc};
    always_comb begin
        vld_d = vld_q;
        if (clken) vld_d = vld_pipe[READ_LATENCY-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= '0;
            vld_q <= '0;
        end else begin
            s1_q  <= s1_d;
            vld_q <= vld_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [MEM_W-1:0] s2_q, s2_d;
            always_comb begin
                s2_d = s2_q;
                if (clken && vld_q[0]) s2_d = s1_q;
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) s2_q <= '0;
                else          s2_q <= s2_d;
            end
            assign out_word = s2_q;
        end else begin : g_lat1
            assign out_word = s1_q;
        end
    endgenerate

    assign readdata      = out_word[DATA_W-1:0];
    assign readdatavalid = vld_pipe[READ_LATENCY] & clken;

`ifdef TMC_ONCHIP_RAM_PARITY_EN
    logic perr_q, perr_d, perr_now;

    function automatic logic par_bad(input logic [MEM_W-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < NB; b++) bad |= ^{w[DATA_W+b], w[b*8 +: 8]};
        return bad;
    endfunction

    // The flag is raised combinationally so it is visible in the readdatavalid cycle itself.
    assign perr_now = readdatavalid & par_bad(out_word);
    always_comb perr_d = perr_q | perr_now;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perr_q <= 1'b0;
        else          perr_q <= perr_d;
    end

    assign parity_err = perr_q | perr_now;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tmc_onchip_ram_pipe.sv
// Scoreboard bench: two instances (DEPTH=16/latency 2 and DEPTH=12/latency 1) share one command bus.
module tb_tmc_onchip_ram_pipe;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  address = '0;
    logic [3:0]  byteenable = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        clken = 1'b1;

    logic [31:0] a_rdata, b_rdata;
    logic        a_rdv, b_rdv, a_wr, b_wr, a_idone, b_idone, a_perr, b_perr;

    tmc_onchip_ram_pipe #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .READ_LATENCY(LAT_A), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .readdata(a_rdata), .readdatavalid(a_rdv), .waitrequest(a_wr),
        .init_done(a_idone), .parity_err(a_perr));

    tmc_onchip_ram_pipe #(.DATA_W(32), .DEPTH(12), .ADDR_W(5), .READ_LATENCY(LAT_B), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .readdata(b_rdata), .readdatavalid(b_rdv), .waitrequest(b_wr),
        .init_done(b_idone), .parity_err(b_perr));

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    logic [31:0] mdl_a [16];
    logic [31:0] mdl_b [12];
    int   en_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic perr_exp_a = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) if (reset_n && clken) en_cnt++;

    always @(negedge clk) begin
        exp_t e;
        if (a_rdv) begin
            if (qa.size() == 0) chk("a_unexpected_rdv", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_rdata", a_rdata, e.data);
                chk("a_latency", en_cnt, e.due);
            end
            chk("a_parity_err", {31'd0, a_perr}, {31'd0, perr_exp_a});
        end
        if (b_rdv) begin
            if (qb.size() == 0) chk("b_unexpected_rdv", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_rdata", b_rdata, e.data);
                chk("b_latency", en_cnt, e.due);
            end
            chk("b_parity_err", {31'd0, b_perr}, 32'd0);
        end
    end

    task automatic idle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [4:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        int k;
        k = 0;
        while ((a_wr || b_wr) && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 100) chk("wait_timeout", 32'd1, 32'd0);
        chipselect = 1'b1; read = rd; write = wr; address = a; byteenable = be; writedata = d;
        @(posedge clk); #1;
        if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) begin
                if (a < 16) mdl_a[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
                if (a < 12) mdl_b[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
            end
        end else if (rd) begin
            e.data = (a < 16) ? mdl_a[a[3:0]] : 32'd0;
            e.due  = en_cnt + LAT_A - 1;
            qa.push_back(e);
            e.data = (a < 12) ? mdl_b[a[3:0]] : 32'd0;
            e.due  = en_cnt + LAT_B - 1;
            qb.push_back(e);
        end
    endtask

    task automatic drain();
        int k;
        idle();
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
            @(negedge clk); k++;
        end
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        clken = 1'b1;
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_a_rdv", {31'd0, a_rdv}, 32'd0);
        chk("rst_a_wait", {31'd0, a_wr}, 32'd1);
        chk("rst_a_idone", {31'd0, a_idone}, 32'd0);
        chk("rst_a_perr", {31'd0, a_perr}, 32'd0);
        chk("rst_b_rdv", {31'd0, b_rdv}, 32'd0);
        chk("rst_b_idone", {31'd0, b_idone}, 32'd0);
        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 11) chk("b_init_busy", {31'd0, b_idone}, 32'd0);
            if (i == 12) chk("b_init_done", {31'd0, b_idone}, 32'd1);
            if (i == 15) begin
                chk("a_init_busy", {31'd0, a_idone}, 32'd0);
                chk("a_init_wait", {31'd0, a_wr}, 32'd1);
            end
            if (i == 16) begin
                chk("a_init_done", {31'd0, a_idone}, 32'd1);
                chk("a_run_wait", {31'd0, a_wr}, 32'd0);
            end
        end
        for (int i = 0; i < 16; i++) mdl_a[i] = 32'd0;
        for (int i = 0; i < 12; i++) mdl_b[i] = 32'd0;
    endtask

    initial begin
        do_reset();

        for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, 5'(i), 4'hF, 32'd0);
        drain();

        for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 5'(i), 4'hF, 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 5'(i), 4'hF, 32'd0);
        drain();

        issue(1'b0, 1'b1, 5'd5, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 1'b1, 5'd5, 4'h1, 32'h000000AA);
        issue(1'b1, 1'b0, 5'd5, 4'hF, 32'd0);
        drain();

        issue(1'b0, 1'b1, 5'd12, 4'hF, 32'h00000055);
        issue(1'b1, 1'b0, 5'd12, 4'hF, 32'd0);
        issue(1'b0, 1'b1, 5'd11, 4'hF, 32'h12345678);
        issue(1'b1, 1'b0, 5'd11, 4'hF, 32'd0);
        issue(1'b0, 1'b1, 5'd20, 4'hF, 32'hFFFFFFFF);
        issue(1'b1, 1'b0, 5'd20, 4'hF, 32'd0);
        drain();

        issue(1'b0, 1'b1, 5'd9, 4'hF, 32'hCAFEF00D);
        issue(1'b1, 1'b0, 5'd9, 4'hF, 32'd0);
        issue(1'b0, 1'b1, 5'd9, 4'hF, 32'h0BADC0DE);
        issue(1'b1, 1'b0, 5'd9, 4'hF, 32'd0);
        issue(1'b1, 1'b1, 5'd2, 4'hF, 32'h22222222);
        issue(1'b1, 1'b0, 5'd2, 4'hF, 32'd0);
        issue(1'b0, 1'b1, 5'd3, 4'h0, 32'hFFFFFFFF);
        issue(1'b1, 1'b0, 5'd3, 4'hF, 32'd0);
        issue(1'b0, 1'b1, 5'd4, 4'hC, 32'hA1B2C3D4);
        issue(1'b1, 1'b0, 5'd4, 4'hF, 32'd0);
        drain();

        issue(1'b1, 1'b0, 5'd1, 4'hF, 32'd0);
        idle();
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_a_wait", {31'd0, a_wr}, 32'd1);
            chk("frz_b_wait", {31'd0, b_wr}, 32'd1);
            chk("frz_rdv", {30'd0, a_rdv, b_rdv}, 32'd0);
            @(posedge clk); #1;
        end
        clken = 1'b1;
        drain();

`ifdef TMC_ONCHIP_RAM_PARITY_EN
        u_a.ram[7][16] = ~u_a.ram[7][16];
        mdl_a[7] = mdl_a[7] ^ 32'h00010000;
        perr_exp_a = 1'b1;
        issue(1'b1, 1'b0, 5'd7, 4'hF, 32'd0);
        drain();
        repeat (3) @(negedge clk);
        chk("a_perr_sticky", {31'd0, a_perr}, 32'd1);
        perr_exp_a = 1'b0;
`endif

        issue(1'b1, 1'b0, 5'd1, 4'hF, 32'd0);
        do_reset();
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        do_reset();
        issue(1'b1, 1'b0, 5'd5, 4'hF, 32'd0);
        issue(1'b1, 1'b0, 5'd12, 4'hF, 32'd0);
        issue(1'b1, 1'b0, 5'd0, 4'hF, 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
